// File: rtl/id_release_tracker.sv
// rtl/id_release_tracker.sv - per-ID metadata tracker, completion register and free-list release queue
// Optional per-ID age limit enabled by defining TRACKER_TIMEOUT_EN.
module id_release_tracker #(
  parameter int NUM_IDS        = 8,
  parameter int ID_WIDTH       = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1,
  parameter int META_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  alloc_valid_i,
  input  logic [ID_WIDTH-1:0]   alloc_id_i,
  input  logic [META_WIDTH-1:0] alloc_meta_i,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [ID_WIDTH-1:0]   rsp_id_i,
  input  logic                  rsp_last_i,
  output logic                  cpl_valid_o,
  input  logic                  cpl_ready_i,
  output logic [ID_WIDTH-1:0]   cpl_id_o,
  output logic [META_WIDTH-1:0] cpl_meta_o,
  output logic                  rel_push_o,
  output logic [ID_WIDTH-1:0]   rel_id_o,
  input  logic                  rel_full_i,
  output logic [ID_WIDTH:0]     outstanding_o,
  output logic                  err_o,
  output logic                  timeout_o
);

  logic [NUM_IDS-1:0]    r_valid;
  logic [META_WIDTH-1:0] r_meta [NUM_IDS];
  logic [ID_WIDTH:0]     r_outstanding;
  logic                  r_cpl_valid;
  logic [ID_WIDTH-1:0]   r_cpl_id;
  logic [META_WIDTH-1:0] r_cpl_meta;
  logic [ID_WIDTH-1:0]   r_rq [NUM_IDS];
  logic [ID_WIDTH-1:0]   r_rq_wr;
  logic [ID_WIDTH-1:0]   r_rq_rd;
  logic [ID_WIDTH:0]     r_rq_cnt;
  logic                  r_err;

  logic w_rsp_ready;
  logic w_rsp_fire;
  logic w_rsp_hit;
  logic w_rsp_miss;
  logic w_alloc_ok;
  logic w_alloc_dup;
  logic w_cpl_fire;
  logic w_rel_fire;

  function automatic logic [ID_WIDTH-1:0] f_ptr_inc(input logic [ID_WIDTH-1:0] p);
    return (p == ID_WIDTH'(NUM_IDS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lookups use the pre-alloc table; a hit and a successful alloc can never share an ID.
  assign w_rsp_ready = ~r_cpl_valid | cpl_ready_i;
  assign w_rsp_fire  = rsp_valid_i & w_rsp_ready;
  assign w_rsp_hit   = w_rsp_fire & rsp_last_i & r_valid[rsp_id_i];
  assign w_rsp_miss  = w_rsp_fire & rsp_last_i & ~r_valid[rsp_id_i];
  assign w_alloc_ok  = alloc_valid_i & ~r_valid[alloc_id_i];
  assign w_alloc_dup = alloc_valid_i & r_valid[alloc_id_i];
  assign w_cpl_fire  = r_cpl_valid & cpl_ready_i;
  assign w_rel_fire  = (r_rq_cnt != '0) & ~rel_full_i;

  assign rsp_ready_o   = w_rsp_ready;
  assign cpl_valid_o   = r_cpl_valid;
  assign cpl_id_o      = r_cpl_id;
  assign cpl_meta_o    = r_cpl_meta;
  assign rel_push_o    = w_rel_fire;
  assign rel_id_o      = r_rq[r_rq_rd];
  assign outstanding_o = r_outstanding;
  assign err_o         = r_err;

  // Storage arrays carry no reset; their contents are qualified by r_valid / r_rq_cnt.
  always_ff @(posedge clk_i) begin
    if (w_alloc_ok) r_meta[alloc_id_i] <= alloc_meta_i;
    if (w_cpl_fire) r_rq[r_rq_wr] <= r_cpl_id;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid       <= '0;
      r_outstanding <= '0;
      r_cpl_valid   <= 1'b0;
      r_cpl_id      <= '0;
      r_cpl_meta    <= '0;
      r_rq_wr       <= '0;
      r_rq_rd       <= '0;
      r_rq_cnt      <= '0;
      r_err         <= 1'b0;
    end else if (flush_i) begin
      r_valid       <= '0;
      r_outstanding <= '0;
      r_cpl_valid   <= 1'b0;
      r_cpl_id      <= '0;
      r_cpl_meta    <= '0;
      r_rq_wr       <= '0;
      r_rq_rd       <= '0;
      r_rq_cnt      <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_rsp_hit)  r_valid[rsp_id_i]   <= 1'b0;
      if (w_alloc_ok) r_valid[alloc_id_i] <= 1'b1;
      r_outstanding <= r_outstanding + (ID_WIDTH+1)'(w_alloc_ok) - (ID_WIDTH+1)'(w_rsp_hit);

      if (w_rsp_hit) begin
        r_cpl_valid <= 1'b1;
        r_cpl_id    <= rsp_id_i;
        r_cpl_meta  <= r_meta[rsp_id_i];
      end else if (cpl_ready_i) begin
        r_cpl_valid <= 1'b0;
      end

      if (w_cpl_fire) r_rq_wr <= f_ptr_inc(r_rq_wr);
      if (w_rel_fire) r_rq_rd <= f_ptr_inc(r_rq_rd);
      case ({w_cpl_fire, w_rel_fire})
        2'b10:   r_rq_cnt <= r_rq_cnt + 1'b1;
        2'b01:   r_rq_cnt <= r_rq_cnt - 1'b1;
        default: r_rq_cnt <= r_rq_cnt;
      endcase

      if (w_alloc_dup | w_rsp_miss) r_err <= 1'b1;
    end
  end

`ifdef TRACKER_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [AGE_W-1:0] r_age [NUM_IDS];
  logic             r_timeout;

  assign timeout_o = r_timeout;

  // Age saturates at TIMEOUT_CYCLES; the flag is raised on the edge the age reaches it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_IDS; i++) r_age[i] <= '0;
      r_timeout <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < NUM_IDS; i++) r_age[i] <= '0;
      r_timeout <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if (w_alloc_ok && (alloc_id_i == ID_WIDTH'(i))) begin
          r_age[i] <= '0;
        end else if (r_valid[i] && (r_age[i] != AGE_W'(TIMEOUT_CYCLES))) begin
          r_age[i] <= r_age[i] + 1'b1;
          if (r_age[i] == AGE_W'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_id_release_tracker.sv
// tb/tb_id_release_tracker.sv - scoreboard bench for id_release_tracker
// Expected completions/releases are queued by stimulus and checked by a negedge monitor.
module tb_id_release_tracker;

  localparam int NUM_IDS  = 8;
  localparam int ID_WIDTH = 3;
  localparam int META_W   = 32;
  localparam int TO_CYC   = 16;
`ifdef TRACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                flush_i = 1'b0;
  logic                alloc_valid_i = 1'b0;
  logic [ID_WIDTH-1:0] alloc_id_i = '0;
  logic [META_W-1:0]   alloc_meta_i = '0;
  logic                rsp_valid_i = 1'b0;
  logic                rsp_ready_o;
  logic [ID_WIDTH-1:0] rsp_id_i = '0;
  logic                rsp_last_i = 1'b0;
  logic                cpl_valid_o;
  logic                cpl_ready_i = 1'b1;
  logic [ID_WIDTH-1:0] cpl_id_o;
  logic [META_W-1:0]   cpl_meta_o;
  logic                rel_push_o;
  logic [ID_WIDTH-1:0] rel_id_o;
  logic                rel_full_i = 1'b0;
  logic [ID_WIDTH:0]   outstanding_o;
  logic                err_o;
  logic                timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ID_WIDTH-1:0] cq_id [$];
  logic [META_W-1:0]   cq_meta [$];
  logic [ID_WIDTH-1:0] rq_id [$];
  logic [META_W-1:0]   exp_meta [NUM_IDS];

  id_release_tracker #(
    .NUM_IDS(NUM_IDS),
    .META_WIDTH(META_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i),
    .alloc_id_i(alloc_id_i),
    .alloc_meta_i(alloc_meta_i),
    .rsp_valid_i(rsp_valid_i),
    .rsp_ready_o(rsp_ready_o),
    .rsp_id_i(rsp_id_i),
    .rsp_last_i(rsp_last_i),
    .cpl_valid_o(cpl_valid_o),
    .cpl_ready_i(cpl_ready_i),
    .cpl_id_o(cpl_id_o),
    .cpl_meta_o(cpl_meta_o),
    .rel_push_o(rel_push_o),
    .rel_id_o(rel_id_o),
    .rel_full_i(rel_full_i),
    .outstanding_o(outstanding_o),
    .err_o(err_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_alloc(input logic [ID_WIDTH-1:0] id, input logic [META_W-1:0] meta);
    alloc_valid_i = 1'b1;
    alloc_id_i    = id;
    alloc_meta_i  = meta;
    exp_meta[id]  = meta;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  // Caller pushes any expected completion/release before calling.
  task automatic do_rsp(input logic [ID_WIDTH-1:0] id, input logic last);
    bit done = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_id_i    = id;
    rsp_last_i  = last;
    for (int k = 0; k < 50 && !done; k++) begin
      if (rsp_ready_o) done = 1'b1;
      tick();
    end
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
    chk("rsp_accept_in_budget", {63'd0, done}, 64'd1);
  endtask

  task automatic exp_cpl(input logic [ID_WIDTH-1:0] id, input bit rel);
    cq_id.push_back(id);
    cq_meta.push_back(exp_meta[id]);
    if (rel) rq_id.push_back(id);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (cpl_valid_o && cpl_ready_i) begin
        if (cq_id.size() == 0) begin
          chk("cpl_unexpected", {61'd0, cpl_id_o}, 64'hFF);
        end else begin
          chk("cpl_id", {61'd0, cpl_id_o}, {61'd0, cq_id.pop_front()});
          chk("cpl_meta", {32'd0, cpl_meta_o}, {32'd0, cq_meta.pop_front()});
        end
      end
      if (rel_push_o) begin
        if (rq_id.size() == 0) chk("rel_unexpected", {61'd0, rel_id_o}, 64'hFF);
        else chk("rel_id", {61'd0, rel_id_o}, {61'd0, rq_id.pop_front()});
      end
    end
  end

  initial begin
    // 1: reset state and single transaction
    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_outstanding", {60'd0, outstanding_o}, 64'd0);
    chk("rst_cpl_valid", {63'd0, cpl_valid_o}, 64'd0);
    chk("rst_rel_push", {63'd0, rel_push_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_o}, 64'd0);
    chk("rst_rsp_ready", {63'd0, rsp_ready_o}, 64'd1);
    tick();
    do_alloc(3'd3, 32'hDEAD);
    chk("t1_out_after_alloc", {60'd0, outstanding_o}, 64'd1);
    exp_cpl(3'd3, 1'b1);
    do_rsp(3'd3, 1'b1);
    chk("t1_cpl_latency", {63'd0, cpl_valid_o}, 64'd1);
    chk("t1_out_after_rsp", {60'd0, outstanding_o}, 64'd0);
    tick();
    chk("t1_rel_push_next", {63'd0, rel_push_o}, 64'd1);
    repeat (2) tick();

    // 2: cpl backpressure stalls the response path
    for (int i = 0; i < NUM_IDS; i++) do_alloc(ID_WIDTH'(i), 32'hA000_0000 | i);
    chk("t2_out_8", {60'd0, outstanding_o}, 64'd8);
    cpl_ready_i = 1'b0;
    exp_cpl(3'd5, 1'b1);
    exp_cpl(3'd6, 1'b1);
    do_rsp(3'd5, 1'b1);
    chk("t2_rsp_ready_low", {63'd0, rsp_ready_o}, 64'd0);
    rsp_valid_i = 1'b1;
    rsp_id_i    = 3'd6;
    rsp_last_i  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_cpl_hold_id", {61'd0, cpl_id_o}, 64'd5);
      chk("t2_stall_ready", {63'd0, rsp_ready_o}, 64'd0);
    end
    cpl_ready_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
    chk("t2_out_6", {60'd0, outstanding_o}, 64'd6);
    repeat (4) tick();

    // 3: releases wait for free-list room and leave in completion order
    rel_full_i = 1'b1;
    exp_cpl(3'd1, 1'b1);
    exp_cpl(3'd2, 1'b1);
    exp_cpl(3'd4, 1'b1);
    do_rsp(3'd1, 1'b1);
    do_rsp(3'd2, 1'b1);
    do_rsp(3'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_no_push_full", {63'd0, rel_push_o}, 64'd0);
    end
    rel_full_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("t3_push_consec", {63'd0, rel_push_o}, 64'd1);
    end
    @(negedge clk_i);
    chk("t3_push_done", {63'd0, rel_push_o}, 64'd0);
    tick();
    chk("t3_out_3", {60'd0, outstanding_o}, 64'd3);

    // 4: error cases
    chk("t4_err_clear", {63'd0, err_o}, 64'd0);
    do_rsp(3'd6, 1'b1);
    chk("t4_dead_no_cpl", {63'd0, cpl_valid_o}, 64'd0);
    chk("t4_dead_err", {63'd0, err_o}, 64'd1);
    do_alloc(3'd0, 32'h1111_1111);
    exp_meta[0] = 32'hA000_0000;
    chk("t4_dup_out", {60'd0, outstanding_o}, 64'd3);
    chk("t4_dup_err", {63'd0, err_o}, 64'd1);

    // 5: flush with 4 tracked, 2 queued, 1 in cpl register
    rel_full_i = 1'b1;
    do_alloc(3'd5, 32'hB5);
    do_alloc(3'd6, 32'hB6);
    exp_cpl(3'd5, 1'b0);
    exp_cpl(3'd6, 1'b0);
    do_rsp(3'd5, 1'b1);
    do_rsp(3'd6, 1'b1);
    repeat (2) tick();
    do_alloc(3'd1, 32'hB1);
    do_alloc(3'd2, 32'hB2);
    cpl_ready_i = 1'b0;
    do_rsp(3'd3, 1'b1);
    chk("t5_pre_out", {60'd0, outstanding_o}, 64'd4);
    chk("t5_pre_cpl", {63'd0, cpl_valid_o}, 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i    = 1'b0;
    rel_full_i = 1'b0;
    cpl_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t5_out_0", {60'd0, outstanding_o}, 64'd0);
    chk("t5_cpl_0", {63'd0, cpl_valid_o}, 64'd0);
    chk("t5_rel_0", {63'd0, rel_push_o}, 64'd0);
    chk("t5_err_0", {63'd0, err_o}, 64'd0);
    tick();
    do_alloc(3'd3, 32'h5A5A_0003);
    exp_cpl(3'd3, 1'b1);
    do_rsp(3'd3, 1'b1);
    repeat (3) tick();

    // 6: age limit
    chk("t6_timeout_pre", {63'd0, timeout_o}, 64'd0);
    do_alloc(3'd2, 32'hC2);
    for (int k = 1; k < TO_CYC; k++) begin
      tick();
      chk("t6_timeout_early", {63'd0, timeout_o}, 64'd0);
    end
    tick();
    chk("t6_timeout_at_limit", {63'd0, timeout_o}, {63'd0, TO_EN});

    for (int k = 0; k < 20 && (cq_id.size() != 0 || rq_id.size() != 0); k++) tick();
    chk("cpl_queue_drained", 64'(cq_id.size()), 64'd0);
    chk("rel_queue_drained", 64'(rq_id.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
